// File: rtl/muldiv_if.sv
// Request/response bundle between the control unit / register file and muldiv_unit.
// The master side drives the request; the slave side is the multiply/divide unit.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd_i;
    logic            hold;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_o;
    logic            wr_en;

    modport master (
        output start, op, a, b, rd_i, hold,
        input  busy, done, result, rd_o, wr_en
    );

    modport slave (
        input  start, op, a, b, rd_i, hold,
        output busy, done, result, rd_o, wr_en
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply, restoring divide.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use one combinational 33x33 multiply.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic     clk,
    input logic     rstn,
    muldiv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    op_t             op_q;
    logic [4:0]      rd_q;
    logic            neg_a_q, neg_b_q, special_q;
    logic [XLEN-1:0] mag_a_q, mag_b_q, hi_q, lo_q, spec_q, result_q;

    logic accept, last;
    assign accept = (state_q == IDLE) && bus.start && !bus.hold;
    assign last   = (state_q == CALC) && !bus.hold && (cnt_q == '1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (last)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic busy_c, done_c;
    always_comb begin
        busy_c = (state_q != IDLE);
        done_c = (state_q == DONE);
    end

    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
    assign bus.wr_en  = done_c;
    assign bus.result = result_q;
    assign bus.rd_o   = rd_q;

    // Operand decode at acceptance: sign flags and magnitudes.
    op_t             op_in;
    logic            sign_a_op, sign_b_op, neg_a_in, neg_b_in, special_in;
    logic [XLEN-1:0] mag_a_in, mag_b_in, spec_in;

    assign op_in     = op_t'(bus.op);
    assign sign_a_op = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign sign_b_op = op_in inside {OP_MULH, OP_DIV, OP_REM};
    assign neg_a_in  = sign_a_op && bus.a[XLEN-1];
    assign neg_b_in  = sign_b_op && bus.b[XLEN-1];
    assign mag_a_in  = neg_a_in ? -bus.a : bus.a;
    assign mag_b_in  = neg_b_in ? -bus.b : bus.b;

`ifdef MULDIV_FAST_MUL_EN
    // 33-bit signed operands, sign-extended to the 64-bit product width.
    logic signed [2*XLEN-1:0] fast_prod;
    assign fast_prod = $signed({{XLEN{sign_a_op && bus.a[XLEN-1]}}, bus.a}) *
                       $signed({{XLEN{sign_b_op && bus.b[XLEN-1]}}, bus.b});
`endif

    always_comb begin
        special_in = 1'b0;
        spec_in    = '0;
        if (bus.op[2]) begin
            if (bus.b == '0) begin
                special_in = 1'b1;
                spec_in    = bus.op[1] ? bus.a : '1;
            end else if (!bus.op[0] && bus.a == INT_MIN && bus.b == '1) begin
                special_in = 1'b1;
                spec_in    = bus.op[1] ? '0 : INT_MIN;
            end
        end
`ifdef MULDIV_FAST_MUL_EN
        else begin
            special_in = 1'b1;
            spec_in    = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // One iteration step: hi/lo hold {product} for multiply, {remainder, dividend/quotient} for divide.
    logic [XLEN:0]   mul_sum, shifted;
    logic [XLEN-1:0] diff, hi_d, lo_d;
    logic            ge;

    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : '0);
    assign shifted = {hi_q, lo_q[XLEN-1]};
    assign ge      = shifted >= {1'b0, mag_b_q};
    assign diff    = shifted[XLEN-1:0] - mag_b_q;

    always_comb begin
        if (op_q[2]) begin
            hi_d = ge ? diff : shifted[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ge};
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, calc_res;

    assign prod_s = (neg_a_q ^ neg_b_q) ? -{hi_d, lo_d} : {hi_d, lo_d};
    assign quo_s  = (neg_a_q ^ neg_b_q) ? -lo_d : lo_d;
    assign rem_s  = neg_a_q ? -hi_d : hi_d;

    always_comb begin
        if (special_q)              calc_res = spec_q;
        else if (op_q[2])           calc_res = op_q[1] ? rem_s : quo_s;
        else if (op_q == OP_MUL)    calc_res = prod_s[XLEN-1:0];
        else                        calc_res = prod_s[2*XLEN-1:XLEN];
    end

    // Special cases preload the counter so the single CALC step lands on DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            op_q      <= OP_MUL;
            rd_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            special_q <= 1'b0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            spec_q    <= '0;
            result_q  <= '0;
        end else if (accept) begin
            cnt_q     <= special_in ? '1 : '0;
            op_q      <= op_in;
            rd_q      <= bus.rd_i;
            neg_a_q   <= neg_a_in;
            neg_b_q   <= neg_b_in;
            special_q <= special_in;
            mag_a_q   <= mag_a_in;
            mag_b_q   <= mag_b_in;
            hi_q      <= '0;
            lo_q      <= bus.op[2] ? mag_a_in : mag_b_in;
            spec_q    <= spec_in;
        end else if (state_q == CALC && !bus.hold) begin
            cnt_q <= cnt_q + CNT_W'(1);
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            if (last) result_q <= calc_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, special cases,
// start-while-busy, hold and asynchronous reset abort.
module tb_muldiv_unit;

    localparam int LIMIT = 200;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    muldiv_if bus ();
    muldiv_unit dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for done; lat = cycles after E0 (done in cycle E0+lat), 0 on timeout.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output int lat,
                          output int busy_cycles);
        bus.op = op; bus.a = a; bus.b = b; bus.rd_i = rd; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        for (int n = 1; n <= LIMIT; n++) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                lat = n;
                break;
            end
            tick();
        end
        res = bus.result;
        tick();
    endtask

    task automatic test_reset();
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
        total_cnt++; if (bus.wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", bus.wr_en); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'h0) $display("FAIL reset_result got %h want 0", bus.result); else pass_cnt++;
        total_cnt++; if (bus.rd_o !== 5'd0) $display("FAIL reset_rd_o got %0d want 0", bus.rd_o); else pass_cnt++;
    endtask

    task automatic test_mul_latency();
        logic [31:0] res;
        int lat, bc;
        bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'd6; bus.rd_i = 5'd5; bus.start = 1'b1;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL mul_busy_pre got %b want 0", bus.busy); else pass_cnt++;
        tick();
        bus.start = 1'b0;
        lat = 0; bc = 0;
        for (int n = 1; n <= LIMIT; n++) begin
            if (bus.busy) bc++;
            if (bus.done) begin
                lat = n;
                total_cnt++; if (bus.wr_en !== 1'b1) $display("FAIL mul_wr_en got %b want 1", bus.wr_en); else pass_cnt++;
                total_cnt++; if (bus.rd_o !== 5'd5) $display("FAIL mul_rd_o got %0d want 5", bus.rd_o); else pass_cnt++;
                break;
            end
            tick();
        end
        res = bus.result;
        total_cnt++; if (res !== 32'd42) $display("FAIL mul_result got %h want %h", res, 32'd42); else pass_cnt++;
        total_cnt++; if (lat !== MUL_LAT) $display("FAIL mul_latency got %0d want %0d", lat, MUL_LAT); else pass_cnt++;
        total_cnt++; if (bc !== MUL_LAT) $display("FAIL mul_busy_cycles got %0d want %0d", bc, MUL_LAT); else pass_cnt++;
        tick();
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL mul_done_pulse got %b want 0", bus.done); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL mul_busy_post got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'd42) $display("FAIL mul_result_held got %h want %h", bus.result, 32'd42); else pass_cnt++;
    endtask

    task automatic test_vectors();
        vec_t v[10];
        logic [31:0] res;
        int lat, bc;
        v[0] = '{"mulh_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
        v[1] = '{"mulhu_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
        v[2] = '{"mulhsu_neg", 3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT};
        v[3] = '{"div_neg",    3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
        v[4] = '{"rem_neg",    3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
        v[5] = '{"divu",       3'd5, 32'd100,      32'd7,        32'd14,       33};
        v[6] = '{"remu",       3'd7, 32'd100,      32'd7,        32'd2,        33};
        v[7] = '{"divu_by0",   3'd5, 32'h1234,     32'h0,        32'hFFFFFFFF, 2};
        v[8] = '{"rem_by0",    3'd6, 32'h1234,     32'h0,        32'h1234,     2};
        v[9] = '{"div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, 5'(i), res, lat, bc);
            total_cnt++; if (res !== v[i].exp) $display("FAIL %s result got %h want %h", v[i].name, res, v[i].exp); else pass_cnt++;
            total_cnt++; if (lat !== v[i].lat) $display("FAIL %s latency got %0d want %0d", v[i].name, lat, v[i].lat); else pass_cnt++;
        end
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd3, res, lat, bc);
        total_cnt++; if (res !== 32'h0) $display("FAIL rem_ovf result got %h want 0", res); else pass_cnt++;
    endtask

    // Re-pulse start mid-operation, then freeze with hold for 10 cycles.
    task automatic test_hold_restart();
        int lat = 0;
        bus.op = 3'd5; bus.a = 32'd1000; bus.b = 32'd8; bus.rd_i = 5'd12; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 1; n <= LIMIT; n++) begin
            if (bus.done) begin
                lat = n;
                break;
            end
            if (n == 5) begin
                bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd99; bus.b = 32'd99; bus.rd_i = 5'd9;
            end
            if (n == 6)  bus.start = 1'b0;
            if (n == 10) bus.hold = 1'b1;
            if (n == 20) bus.hold = 1'b0;
            tick();
        end
        total_cnt++; if (bus.result !== 32'd125) $display("FAIL hold_result got %0d want 125", bus.result); else pass_cnt++;
        total_cnt++; if (bus.rd_o !== 5'd12) $display("FAIL hold_rd_o got %0d want 12", bus.rd_o); else pass_cnt++;
        total_cnt++; if (lat !== 43) $display("FAIL hold_latency got %0d want 43", lat); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_abort();
        logic [31:0] res;
        int lat, bc;
        int seen_done = 0;
        bus.op = 3'd0; bus.a = 32'd11; bus.b = 32'd13; bus.rd_i = 5'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 1; n < 15; n++) tick();
        #2 rstn = 1'b0;
        #1;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'h0) $display("FAIL abort_result got %h want 0", bus.result); else pass_cnt++;
        @(negedge clk);
        rstn = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (bus.done) seen_done++;
        end
        total_cnt++; if (seen_done !== 0) $display("FAIL abort_no_done got %0d pulses want 0", seen_done); else pass_cnt++;
        run_op(3'd0, 32'd3, 32'd5, 5'd7, res, lat, bc);
        total_cnt++; if (res !== 32'd15) $display("FAIL post_reset_mul got %0d want 15", res); else pass_cnt++;
        total_cnt++; if (lat !== MUL_LAT) $display("FAIL post_reset_latency got %0d want %0d", lat, MUL_LAT); else pass_cnt++;
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.rd_i = '0; bus.hold = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rstn = 1'b1;
        tick();
        test_mul_latency();
        test_vectors();
        test_hold_restart();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
